multichannel_iir_filter: RTL and testbench
==========================================

# multichannel_iir_filter

Parametrised, time-multiplexed first-order IIR filter bank that generalises the single-channel shift-coefficient low-pass filter to CHANNELS independent channels, configurable widths, per-channel coefficient and low-/high-pass mode. It sits between the ADC driver's sample outputs and the DAC driver's inputs, is triggered once per conversion frame, and processes the channels sequentially through one shared datapath.

## Interface
- WIDTH, 20, signed two's-complement sample width (in and out)
- CHANNELS, 2, number of independent channels (1..16)
- KW, 4, width of each per-channel shift coefficient k
- GUARD, 16, extra fractional accumulator bits; must be ≥ 2^KW−1
- qzt_clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe: new frame on Vin
- sample_ready  out  1  high when a frame can be accepted
- Vin  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- k  in  CHANNELS*KW  per-channel shift; larger = lower cutoff
- mode  in  CHANNELS  per-channel: 0 = low-pass, 1 = high-pass
- Vout  out  CHANNELS*WIDTH  filtered outputs, same packing as Vin
- out_valid  out  1  one-cycle pulse when all Vout lanes updated
- overrun  out  1  sticky: sample_valid arrived while busy

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: sample_ready=1. On sample_valid: latch Vin, k, mode into frame registers; ch=0; go CALC.
- CALC: one channel per cycle. acc_c width WIDTH+GUARD signed; x = Vin_c<<GUARD.
  - acc_c ← acc_c + ((x − acc_c) >>> k_c), arithmetic shift, difference computed at WIDTH+GUARD+1 bits, result truncated to WIDTH+GUARD.
  - k_c = 0: acc_c ← x (pass-through).
  - lp = acc_c_new[WIDTH+GUARD−1 -: WIDTH] (truncate toward −inf).
  - Vout_c ← lp (mode 0) or sat(Vin_c − lp) (mode 1), difference at WIDTH+1 bits, saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - ch == CHANNELS−1 → DONE, else ch+1.
- DONE: out_valid=1 for one cycle; → IDLE.
- sample_valid outside IDLE: ignored, overrun←1 (cleared only by reset). Same-cycle arrival in DONE is also an overrun.
- Vout lanes update individually during CALC; consumers sample on out_valid.

## Timing
- Reset: state=IDLE, all acc_c=0, Vout=0, out_valid=0, overrun=0, sample_ready=1 (first cycle after reset deassert).
- Latency: sample_valid at cycle T → out_valid at T+CHANNELS+1; sample_ready low from T+1 through T+CHANNELS+1.
- Throughput: one frame per CHANNELS+2 cycles; back-to-back strobe accepted on the cycle after out_valid.
- Reset asserted mid-CALC: frame aborted, no out_valid, all state cleared next cycle.
- Frame inputs are latched; changing Vin/k/mode during CALC has no effect on the current frame.

## Configuration
- IIR_HPF_MODE_EN defined: mode port effective, high-pass path and saturator compiled in.
- Undefined: mode port present but ignored, every channel low-pass, subtractor/saturator absent.

## Structure
- Package iir_pkg: FSM state enum (IDLE, CALC, DONE), saturate function, default parameter constants.
- One sub-module: iir_channel_update — combinational single-channel datapath (acc, x, k, mode in; acc_new, y out), instantiated once and shared across channels.
- Top holds FSM, channel counter, frame registers, acc register array, output lanes.

## Test plan
- Reset then idle: Vout=0, out_valid=0, sample_ready=1, overrun=0 held for 20 cycles.
- CHANNELS=2, k=0 both, mode 0, Vin=(1000, −1000) → out_valid at T+3, Vout=(1000, −1000).
- Step: ch0 k=1, Vin=4096 repeated → Vout ch0 = 2048, 3072, 3584, 3840 on successive frames.
- High-pass (macro defined): ch1 k=1 mode 1, Vin=4096 repeated → 2048, 1024, 512, 256; Vin=−2^19 after acc at +2^19−1 → saturates to −524288.
- Overrun: second sample_valid at T+1 → ignored, overrun=1 stays high, single out_valid at T+3.
- Reset at T+2 mid-CALC → no out_valid; next frame with k=1, Vin=4096 yields 2048 (acc restarted from 0).

Source files
------------

// File: rtl/iir_pkg.sv
// ---------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the multichannel first-order IIR filter bank:
//   - state_t   : sequencer states (IDLE, CALC, DONE)
//   - DEF_*     : default parameter values used by the filter modules
//   - saturate  : clamps a wide signed value into a signed range of 'width'
//                 bits; used by the high-pass path
// Optional feature macro used by the filter files: IIR_HPF_MODE_EN.
// ---------------------------------------------------------------------------
package iir_pkg;

    localparam int DEF_WIDTH    = 20;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_KW       = 4;
    localparam int DEF_GUARD    = 16;

    // Working width of the saturate helper; callers sign-extend into it.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Clamp to [-2^(width-1), 2^(width-1)-1].
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/iir_channel_update.sv
// ---------------------------------------------------------------------------
// iir_channel_update
// Combinational single-channel datapath of the filter bank. One instance is
// shared by all channels; the top presents one channel per cycle.
//   acc     : current accumulator, WIDTH+GUARD bits signed
//   x       : input sample already scaled by 2^GUARD (Vin_c << GUARD)
//   k       : shift coefficient (0 = pass-through)
//   mode    : 0 = low-pass, 1 = high-pass (only with IIR_HPF_MODE_EN)
//   acc_new : updated accumulator
//   y       : channel output sample, WIDTH bits signed
// Macro IIR_HPF_MODE_EN compiles in the high-pass subtractor and saturator;
// without it mode is ignored and y is always the low-pass value.
// ---------------------------------------------------------------------------
module iir_channel_update
    import iir_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = DEF_KW,
    parameter int GUARD = DEF_GUARD
) (
    input  logic signed [WIDTH+GUARD-1:0] acc,
    input  logic signed [WIDTH+GUARD-1:0] x,
    input  logic        [KW-1:0]          k,
    input  logic                          mode,
    output logic signed [WIDTH+GUARD-1:0] acc_new,
    output logic signed [WIDTH-1:0]       y
);

    localparam int AW = WIDTH + GUARD;

    logic signed [AW:0]      diff;
    logic signed [AW:0]      step;
    logic signed [AW:0]      sum;
    logic signed [WIDTH-1:0] lp;
    logic                    unused_sum_msb;

    // One extra bit so x - acc can never wrap.
    assign diff = {x[AW-1], x} - {acc[AW-1], acc};
    assign step = diff >>> k;
    assign sum  = {acc[AW-1], acc} + step;

    // The result always lies between acc and x, so dropping the top bit
    // of the sum loses nothing.
    assign unused_sum_msb = sum[AW];

    always_comb begin
        acc_new = sum[AW-1:0];
        if (k == '0) begin
            acc_new = x;
        end
    end

    // Taking the top WIDTH bits floors toward -inf.
    assign lp = acc_new[AW-1 -: WIDTH];

`ifdef IIR_HPF_MODE_EN
    logic signed [WIDTH-1:0] vin;
    logic signed [WIDTH:0]   hp_diff;
    logic signed [SAT_W-1:0] hp_wide;
    logic                    unused_hp_hi;

    assign vin          = x[AW-1 -: WIDTH];
    assign hp_diff      = {vin[WIDTH-1], vin} - {lp[WIDTH-1], lp};
    assign hp_wide      = saturate(SAT_W'(hp_diff), WIDTH);
    assign unused_hp_hi = ^hp_wide[SAT_W-1:WIDTH];
    assign y            = mode ? hp_wide[WIDTH-1:0] : lp;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign y           = lp;
`endif

endmodule

// File: rtl/multichannel_iir_filter.sv
// ---------------------------------------------------------------------------
// multichannel_iir_filter
// Time-multiplexed bank of CHANNELS first-order shift-coefficient IIR
// filters. A frame strobe latches all inputs; the channels are then updated
// one per cycle through a single shared iir_channel_update datapath.
// Ports:
//   qzt_clk      : system clock
//   reset        : synchronous, active-high
//   sample_valid : one-cycle strobe, new frame on Vin
//   sample_ready : high in IDLE, when a frame can be accepted
//   Vin          : CHANNELS x WIDTH samples, channel c at [c*WIDTH +: WIDTH]
//   k            : CHANNELS x KW shift coefficients
//   mode         : per channel 0 = low-pass, 1 = high-pass
//   Vout         : filtered outputs, same packing as Vin
//   out_valid    : one-cycle pulse once every lane of the frame is updated
//   overrun      : sticky, a strobe arrived while busy (cleared by reset)
// Macro IIR_HPF_MODE_EN enables the high-pass mode; otherwise all channels
// are low-pass and mode is ignored.
// ---------------------------------------------------------------------------
module multichannel_iir_filter
    import iir_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int KW       = DEF_KW,
    parameter int GUARD    = DEF_GUARD
) (
    input  logic                      qzt_clk,
    input  logic                      reset,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [CHANNELS*WIDTH-1:0] Vin,
    input  logic [CHANNELS*KW-1:0]    k,
    input  logic [CHANNELS-1:0]       mode,
    output logic [CHANNELS*WIDTH-1:0] Vout,
    output logic                      out_valid,
    output logic                      overrun
);

    localparam int AW = WIDTH + GUARD;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    state_t                    state_reg;
    state_t                    state_next;
    logic [CW-1:0]             ch_reg;
    logic [CW-1:0]             ch_next;
    logic                      calc_en;

    logic [CHANNELS*WIDTH-1:0] vin_reg;
    logic [CHANNELS*KW-1:0]    k_reg;
    logic [CHANNELS-1:0]       mode_reg;
    logic                      overrun_reg;

    logic signed [AW-1:0]      acc_reg  [CHANNELS];
    logic signed [WIDTH-1:0]   vout_reg [CHANNELS];

    logic signed [WIDTH-1:0]   cur_vin;
    logic signed [AW-1:0]      cur_x;
    logic [KW-1:0]             cur_k;
    logic                      cur_mode;
    logic signed [AW-1:0]      cur_acc;
    logic signed [AW-1:0]      acc_new;
    logic signed [WIDTH-1:0]   y_new;

    // Sequencer: next state and strobes.
    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        sample_ready = 1'b0;
        out_valid    = 1'b0;
        calc_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    state_next = CALC;
                    ch_next    = '0;
                end
            end
            CALC: begin
                calc_en = 1'b1;
                if (ch_reg == LAST_CH) begin
                    state_next = DONE;
                end else begin
                    ch_next = ch_reg + 1'b1;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            vin_reg     <= '0;
            k_reg       <= '0;
            mode_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            if (state_reg == IDLE && sample_valid) begin
                vin_reg  <= Vin;
                k_reg    <= k;
                mode_reg <= mode;
            end
            // Any strobe outside IDLE, including the DONE cycle, is dropped.
            if (state_reg != IDLE && sample_valid) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Present the current channel to the shared datapath.
    assign cur_vin  = vin_reg[ch_reg*WIDTH +: WIDTH];
    assign cur_x    = {cur_vin, {GUARD{1'b0}}};
    assign cur_k    = k_reg[ch_reg*KW +: KW];
    assign cur_mode = mode_reg[ch_reg];
    assign cur_acc  = acc_reg[ch_reg];

    iir_channel_update #(
        .WIDTH (WIDTH),
        .KW    (KW),
        .GUARD (GUARD)
    ) u_update (
        .acc     (cur_acc),
        .x       (cur_x),
        .k       (cur_k),
        .mode    (cur_mode),
        .acc_new (acc_new),
        .y       (y_new)
    );

    // Per-channel filter state and output lanes; only the channel being
    // processed this cycle is written.
    always_ff @(posedge qzt_clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                acc_reg[i]  <= '0;
                vout_reg[i] <= '0;
            end else if (calc_en && ch_reg == CW'(i)) begin
                acc_reg[i]  <= acc_new;
                vout_reg[i] <= y_new;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign Vout[gi*WIDTH +: WIDTH] = vout_reg[gi];
        end
    endgenerate

    assign overrun = overrun_reg;

endmodule

// File: tb/tb_multichannel_iir_filter.sv
// ---------------------------------------------------------------------------
// tb_multichannel_iir_filter
// Directed bench for the two-channel default configuration. Expected values
// are hand-computed; the high-pass expectations apply when IIR_HPF_MODE_EN
// is defined, otherwise the bench expects mode to be ignored.
// ---------------------------------------------------------------------------
module tb_multichannel_iir_filter;

    localparam int W  = 20;
    localparam int CH = 2;
    localparam int KW = 4;

    logic            qzt_clk = 1'b0;
    logic            reset;
    logic            sample_valid;
    logic            sample_ready;
    logic [CH*W-1:0] Vin;
    logic [CH*KW-1:0] k;
    logic [CH-1:0]   mode;
    logic [CH*W-1:0] Vout;
    logic            out_valid;
    logic            overrun;

    int checks = 0;
    int errors = 0;

    always #10 qzt_clk = ~qzt_clk;

    multichannel_iir_filter #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .KW       (KW),
        .GUARD    (16)
    ) dut (
        .qzt_clk      (qzt_clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .Vin          (Vin),
        .k            (k),
        .mode         (mode),
        .Vout         (Vout),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    function automatic longint lane(input int c);
        logic signed [W-1:0] v;
        v = Vout[c*W +: W];
        return longint'(v);
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Strobe one frame, wait (bounded) for out_valid, check latency/ready,
    // then return the lanes seen on the out_valid cycle. Returns on the
    // cycle after out_valid, where the next strobe is back-to-back.
    task automatic run_frame(input int v0, input int v1, input int k0, input int k1,
                             input logic [CH-1:0] m, output longint y0, output longint y1);
        int lat;
        int ready_err;
        Vin          = {W'(v1), W'(v0)};
        k            = {KW'(k1), KW'(k0)};
        mode         = m;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        // Scramble inputs: the frame in flight must be unaffected.
        Vin       = ~Vin;
        k         = ~k;
        mode      = ~mode;
        lat       = 1;
        ready_err = 0;
        while (1) begin
            if (sample_ready) ready_err++;
            if (out_valid || lat >= 20) break;
            tick();
            lat++;
        end
        y0 = lane(0);
        y1 = lane(1);
        $display("frame vin=(%0d,%0d) k=(%0d,%0d) mode=%b -> vout=(%0d,%0d) latency=%0d",
                 v0, v1, k0, k1, m, y0, y1, lat);
        check("latency", lat, CH + 1);
        check("ready_low_busy", ready_err, 0);
        tick();
        check("ready_after_done", sample_ready, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        longint y0, y1;
        int     nvalid;
        longint exp1 [4];
        longint lp_seq [4];

        reset        = 1'b1;
        sample_valid = 1'b0;
        Vin          = '0;
        k            = '0;
        mode         = '0;
        do_reset();

        // Idle after reset: {Vout, out_valid, sample_ready, overrun} = ready only.
        for (int i = 0; i < 20; i++) begin
            check("reset_idle", longint'({Vout, out_valid, sample_ready, overrun}), 2);
            tick();
        end

        // k = 0 pass-through.
        run_frame(1000, -1000, 0, 0, 2'b00, y0, y1);
        check("pass_ch0", y0, 1000);
        check("pass_ch1", y1, -1000);

        // Step response, k = 1, from a cleared accumulator.
        do_reset();
        lp_seq = '{2048, 3072, 3584, 3840};
`ifdef IIR_HPF_MODE_EN
        exp1 = '{2048, 1024, 512, 256};
`else
        exp1 = lp_seq;
`endif
        for (int i = 0; i < 4; i++) begin
            run_frame(4096, 4096, 1, 1, 2'b10, y0, y1);
            check("step_lp_ch0", y0, lp_seq[i]);
            check("step_mode1_ch1", y1, exp1[i]);
        end

        // Push ch1 to full scale, then step to negative full scale.
        run_frame(0, 524287, 0, 0, 2'b10, y0, y1);
        check("fs_ch0", y0, 0);
`ifdef IIR_HPF_MODE_EN
        check("fs_ch1_hp", y1, 0);
`else
        check("fs_ch1_lp", y1, 524287);
`endif
        run_frame(0, -524288, 0, 4, 2'b10, y0, y1);
`ifdef IIR_HPF_MODE_EN
        check("sat_ch1_hp", y1, -524288);
`else
        check("neg_ch1_lp", y1, 458751);
`endif
        check("no_overrun_b2b", overrun, 0);

        // Overrun: second strobe one cycle after the first.
        do_reset();
        Vin          = {W'(0), W'(4096)};
        k            = {KW'(0), KW'(1)};
        mode         = '0;
        sample_valid = 1'b1;
        tick();
        check("overrun_before", overrun, 0);
        tick();
        sample_valid = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) nvalid++;
            tick();
        end
        $display("overrun frame: out_valid pulses=%0d overrun=%0d vout0=%0d", nvalid, overrun, lane(0));
        check("overrun_single_valid", nvalid, 1);
        check("overrun_sticky", overrun, 1);
        check("overrun_frame_ch0", lane(0), 2048);

        // Reset in the middle of CALC.
        Vin          = {W'(4096), W'(4096)};
        k            = {KW'(1), KW'(1)};
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) nvalid++;
            tick();
        end
        $display("mid-calc reset: out_valid pulses=%0d vout0=%0d overrun=%0d", nvalid, lane(0), overrun);
        check("abort_no_valid", nvalid, 0);
        check("abort_vout_cleared", lane(0), 0);
        check("abort_overrun_cleared", overrun, 0);
        check("abort_ready", sample_ready, 1);
        run_frame(4096, 0, 1, 0, 2'b00, y0, y1);
        check("restart_ch0", y0, 2048);
        check("restart_ch1", y1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
